// File: rtl/rst_pkg.sv
// rst_pkg: shared FSM state encoding and reset cause codes for the reset requester.
package rst_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_WDT  = 2'b11
  } cause_t;
endpackage

// File: rtl/rst_requester_if.sv
// rst_requester_if: reset cause inputs and four-phase req/ack handshake toward the pulse generator.
interface rst_requester_if;
  import rst_pkg::*;
  logic   btn_n;
  logic   sw_req;
  logic   wdt_kick;
  logic   rst_ack;
  logic   rst_req;
  logic   rst_req_n;
  logic   busy;
  cause_t cause;
  logic   ack_timeout;
  modport master (
    input  btn_n, sw_req, wdt_kick, rst_ack,
    output rst_req, rst_req_n, busy, cause, ack_timeout
  );
  modport slave (
    output btn_n, sw_req, wdt_kick, rst_ack,
    input  rst_req, rst_req_n, busy, cause, ack_timeout
  );
endinterface

// File: rtl/rst_debounce.sv
// rst_debounce: 2FF-synchronises the active-low button and emits a one-cycle pulse on a debounced press.
module rst_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             done;
  assign differ = sync[1] != level;
  assign done   = differ && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  // Sync stages and level reset to "released" so no press fires out of reset.
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= (differ && !done) ? cnt + 1'b1 : '0;
      level <= done ? sync[1] : level;
      press <= done && level;
    end
endmodule

// File: rtl/rst_requester.sv
// rst_requester: merges button/software/watchdog reset causes into one four-phase request with ack timeout.
// Macro WATCHDOG_EN adds the watchdog counter and its trigger; without it wdt_kick is ignored.
module rst_requester
  import rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned WDT_CYCLES      = 267_777_777,
  parameter int unsigned ACK_TIMEOUT     = 255,
  parameter int unsigned CNT_W           = 32
) (
  input logic             clk_sys,
  input logic             rst,
  rst_requester_if.master bus
);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  state_t        state, state_nx;
  cause_t        cause_nx;
  logic [TW-1:0] req_cnt, req_cnt_nx;
  logic [1:0]    ack_sync;
  logic          ack_s;
  logic          btn_press;
  logic          unused_btn_level;
  logic          wdt_fire;
  logic          trig;
  logic          timeout_nx;
  rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_debounce (
    .clk_sys(clk_sys),
    .rst(rst),
    .raw(bus.btn_n),
    .level(unused_btn_level),
    .press(btn_press)
  );
  assign ack_s = ack_sync[1];
`ifdef WATCHDOG_EN
  logic [CNT_W-1:0] wdt_cnt;
  assign wdt_fire = !bus.wdt_kick && wdt_cnt == CNT_W'(WDT_CYCLES - 1);
  // Held at zero while a request is in flight so a fresh full period follows each reset.
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) wdt_cnt <= '0;
    else wdt_cnt <= (bus.wdt_kick || bus.busy || wdt_cnt == CNT_W'(WDT_CYCLES - 1)) ? '0 : wdt_cnt + 1'b1;
`else
  logic unused_wdt;
  assign unused_wdt = bus.wdt_kick ^ (WDT_CYCLES == 0);
  assign wdt_fire   = 1'b0;
`endif
  assign trig = wdt_fire || btn_press || bus.sw_req;
  always_comb begin
    state_nx   = state;
    cause_nx   = bus.cause;
    req_cnt_nx = '0;
    timeout_nx = bus.ack_timeout;
    case (state)
      IDLE:
        if (trig) begin
          state_nx = REQ;
          cause_nx = wdt_fire ? CAUSE_WDT : btn_press ? CAUSE_BTN : CAUSE_SW;
        end
      REQ:
        if (ack_s) state_nx = RELEASE;
        else if (req_cnt == TW'(ACK_TIMEOUT - 1)) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else req_cnt_nx = req_cnt + 1'b1;
      RELEASE:
        if (!ack_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs come from the next state so they settle on the same edge as the state change.
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) begin
      state           <= IDLE;
      req_cnt         <= '0;
      ack_sync        <= '0;
      bus.rst_req     <= 1'b0;
      bus.rst_req_n   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.cause       <= CAUSE_NONE;
      bus.ack_timeout <= 1'b0;
    end else begin
      state           <= state_nx;
      req_cnt         <= req_cnt_nx;
      ack_sync        <= {ack_sync[0], bus.rst_ack};
      bus.rst_req     <= state_nx == REQ;
      bus.rst_req_n   <= state_nx != REQ;
      bus.busy        <= state_nx != IDLE;
      bus.cause       <= cause_nx;
      bus.ack_timeout <= timeout_nx;
    end
endmodule
